// File: rtl/dca_lsu_load_formatter_pkg.sv
// Shared types and widths for the DCA LSU load-side row formatter.
package dca_lsu_load_formatter_pkg;

  localparam int unsigned MATRIX_NUM_COL   = 4;
  localparam int unsigned BW_LSU_ELEMENT   = 8;
  localparam int unsigned BW_TENSOR_SCALAR = 32;
  localparam int unsigned BW_NUM_ROW_M1    = 4;
  localparam int unsigned BW_NUM_COL_M1    = 2;

  localparam int unsigned BW_LSU_ELEMENT_ROW = MATRIX_NUM_COL * BW_LSU_ELEMENT;
  localparam int unsigned BW_TENSOR_ROW      = MATRIX_NUM_COL * BW_TENSOR_SCALAR;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  // Row buffer entry: formatted tensor row plus the final-row tag.
  typedef struct packed {
    logic                     last;
    logic [BW_TENSOR_ROW-1:0] row;
  } fifo_entry_t;

  localparam int unsigned BW_FIFO_ENTRY = $bits(fifo_entry_t);

  // Widen one LSU element to a tensor scalar; zero fill unless sign extension is selected.
  function automatic logic [BW_TENSOR_SCALAR-1:0] extend_elem(
    input logic [BW_LSU_ELEMENT-1:0] elem,
    input logic                      is_signed
  );
    logic ext_bit;
    ext_bit = is_signed & elem[BW_LSU_ELEMENT-1];
    return {{(BW_TENSOR_SCALAR - BW_LSU_ELEMENT){ext_bit}}, elem};
  endfunction

endpackage

// File: rtl/dca_lsu_load_formatter_if.sv
// Instruction, element-row and tensor-row handshake bundle of the load formatter.
interface dca_lsu_load_formatter_if;
  import dca_lsu_load_formatter_pkg::*;

  logic                          inst_valid;
  logic                          inst_ready;
  logic [BW_NUM_ROW_M1-1:0]      inst_num_row_m1;
  logic [BW_NUM_COL_M1-1:0]      inst_num_col_m1;
  logic                          inst_is_signed;

  logic                          elem_valid;
  logic                          elem_ready;
  logic [BW_LSU_ELEMENT_ROW-1:0] elem_row;

  logic                          tensor_valid;
  logic                          tensor_ready;
  logic [BW_TENSOR_ROW-1:0]      tensor_row;
  logic                          tensor_last;

  logic                          done;

  // Master: instruction issuer, read-data source and tensor consumer.
  modport master (
    output inst_valid, inst_num_row_m1, inst_num_col_m1, inst_is_signed,
    output elem_valid, elem_row,
    output tensor_ready,
    input  inst_ready, elem_ready, tensor_valid, tensor_row, tensor_last, done
  );

  // Slave: the formatter itself.
  modport slave (
    input  inst_valid, inst_num_row_m1, inst_num_col_m1, inst_is_signed,
    input  elem_valid, elem_row,
    input  tensor_ready,
    output inst_ready, elem_ready, tensor_valid, tensor_row, tensor_last, done
  );

endinterface

// File: rtl/dca_lsu_row_fifo2.sv
// Two-entry valid/ready FIFO with a registered head; simultaneous push and pop keep the count.
module dca_lsu_row_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rstnn,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  logic [Width-1:0] push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [Width-1:0] pop_data_o
);

  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = head_q;

  assign push = push_valid_i & push_ready_o;
  assign pop  = pop_valid_o & pop_ready_i;

  // Next-state: the head always holds the oldest entry, the tail the second one.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_data_i;
        end else begin
          tail_d = push_data_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Push is only possible at count 1 here, so the new data becomes the head.
        head_d = push_data_i;
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dca_lsu_load_formatter.sv
// DCA LSU load-side row formatter: widens packed element rows into tensor rows.
// Optional feature macro DCA_LSU_LOAD_COLMASK_EN zeroes columns above the latched column count.
module dca_lsu_load_formatter
  import dca_lsu_load_formatter_pkg::*;
(
  input logic                     clk,
  input logic                     rstnn,
  dca_lsu_load_formatter_if.slave lsu_io
);

  state_e                   state_q;
  logic                     inst_ready_q;
  logic                     done_q;
  logic [BW_NUM_ROW_M1-1:0] num_row_m1_q;
  logic [BW_NUM_ROW_M1-1:0] row_cnt_q;
  logic                     is_signed_q;
`ifdef DCA_LSU_LOAD_COLMASK_EN
  logic [BW_NUM_COL_M1-1:0] num_col_m1_q;
`endif

  logic                     fifo_push_ready;
  logic                     fifo_pop_valid;
  logic [BW_FIFO_ENTRY-1:0] fifo_pop_data;
  fifo_entry_t              push_entry;
  fifo_entry_t              pop_entry;
  logic [BW_TENSOR_ROW-1:0] fmt_row;

  logic elem_ready;
  logic elem_accept;
  logic elem_is_last;
  logic last_pop;

  assign elem_ready   = (state_q == StRun) & fifo_push_ready;
  assign elem_accept  = lsu_io.elem_valid & elem_ready;
  assign elem_is_last = (row_cnt_q == num_row_m1_q);

  assign pop_entry = fifo_entry_t'(fifo_pop_data);
  assign last_pop  = fifo_pop_valid & lsu_io.tensor_ready & pop_entry.last;

  // Per-column widening at push time, using the instruction's latched signedness.
  for (genvar gi = 0; gi < MATRIX_NUM_COL; gi++) begin : g_col
    logic [BW_TENSOR_SCALAR-1:0] ext;
    assign ext = extend_elem(lsu_io.elem_row[gi*BW_LSU_ELEMENT +: BW_LSU_ELEMENT], is_signed_q);
`ifdef DCA_LSU_LOAD_COLMASK_EN
    assign fmt_row[gi*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] =
        (gi > int'(num_col_m1_q)) ? '0 : ext;
`else
    assign fmt_row[gi*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = ext;
`endif
  end

  assign push_entry.last = elem_is_last;
  assign push_entry.row  = fmt_row;

  dca_lsu_row_fifo2 #(
    .Width (BW_FIFO_ENTRY)
  ) u_row_fifo (
    .clk          (clk),
    .rstnn        (rstnn),
    .push_valid_i (elem_accept),
    .push_ready_o (fifo_push_ready),
    .push_data_i  (push_entry),
    .pop_valid_o  (fifo_pop_valid),
    .pop_ready_i  (lsu_io.tensor_ready),
    .pop_data_o   (fifo_pop_data)
  );

  // Control FSM: latch the instruction, count accepted rows, finish on the last-tagged pop.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= StIdle;
      inst_ready_q <= 1'b1;
      done_q       <= 1'b0;
      num_row_m1_q <= '0;
      row_cnt_q    <= '0;
      is_signed_q  <= 1'b0;
`ifdef DCA_LSU_LOAD_COLMASK_EN
      num_col_m1_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lsu_io.inst_valid) begin
            num_row_m1_q <= lsu_io.inst_num_row_m1;
            is_signed_q  <= lsu_io.inst_is_signed;
`ifdef DCA_LSU_LOAD_COLMASK_EN
            num_col_m1_q <= lsu_io.inst_num_col_m1;
`endif
            row_cnt_q    <= '0;
            inst_ready_q <= 1'b0;
            state_q      <= StRun;
          end
        end
        StRun: begin
          if (elem_accept) begin
            // Stop counting on the last row so the counter never wraps.
            if (elem_is_last) begin
              state_q <= StDrain;
            end else begin
              row_cnt_q <= row_cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (last_pop) begin
            done_q       <= 1'b1;
            inst_ready_q <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: begin
          inst_ready_q <= 1'b1;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign lsu_io.inst_ready   = inst_ready_q;
  assign lsu_io.elem_ready   = elem_ready;
  assign lsu_io.tensor_valid = fifo_pop_valid;
  assign lsu_io.tensor_row   = pop_entry.row;
  assign lsu_io.tensor_last  = pop_entry.last;
  assign lsu_io.done         = done_q;

endmodule

// File: tb/tb_dca_lsu_load_formatter.sv
// Self-checking bench for dca_lsu_load_formatter: vector table plus directed corner sequences.
module tb_dca_lsu_load_formatter;
  import dca_lsu_load_formatter_pkg::*;

  logic clk;
  logic rstnn;

  dca_lsu_load_formatter_if u_if ();

  dca_lsu_load_formatter u_dut (
    .clk    (clk),
    .rstnn  (rstnn),
    .lsu_io (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic         sgn;
    logic [31:0]  row;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs[6];
  logic [31:0]  bp_in[3];
  logic [127:0] bp_exp[3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_ready"}, u_if.inst_ready, 1'b1);
    check({tag, "_elem_ready"}, u_if.elem_ready, 1'b0);
    check({tag, "_tvalid"}, u_if.tensor_valid, 1'b0);
    check({tag, "_trow"}, u_if.tensor_row, 128'h0);
    check({tag, "_tlast"}, u_if.tensor_last, 1'b0);
    check({tag, "_done"}, u_if.done, 1'b0);
  endtask

  // Issue one instruction; returns at the negedge after acceptance (state RUN).
  task automatic start_inst(input logic [3:0] m1, input logic [1:0] c1, input logic sgn);
    int n;
    n = 0;
    @(negedge clk);
    while (!u_if.inst_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("inst_ready_wait", u_if.inst_ready, 1'b1);
    u_if.inst_valid      = 1'b1;
    u_if.inst_num_row_m1 = m1;
    u_if.inst_num_col_m1 = c1;
    u_if.inst_is_signed  = sgn;
    @(negedge clk);
    u_if.inst_valid = 1'b0;
  endtask

  // Send the only/last row of a one-row instruction; returns at the done negedge.
  task automatic send_single(input string name, input logic [31:0] row, input logic [127:0] exp);
    u_if.tensor_ready = 1'b1;
    u_if.elem_valid   = 1'b1;
    u_if.elem_row     = row;
    check({name, "_elem_ready"}, u_if.elem_ready, 1'b1);
    @(negedge clk);
    u_if.elem_valid = 1'b0;
    check({name, "_tvalid"}, u_if.tensor_valid, 1'b1);
    check({name, "_row"}, u_if.tensor_row, exp);
    check({name, "_last"}, u_if.tensor_last, 1'b1);
    @(negedge clk);
    check({name, "_done"}, u_if.done, 1'b1);
    check({name, "_idle"}, u_if.inst_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           got;
    int           dones;
    logic         accept_pending;
    logic [127:0] mask_exp;

    vecs[0] = '{"sgn_mix",  1'b1, 32'h7F8001FF,
                {32'h0000007F, 32'hFFFFFF80, 32'h00000001, 32'hFFFFFFFF}};
    vecs[1] = '{"uns_mix",  1'b0, 32'h7F8001FF,
                {32'h0000007F, 32'h00000080, 32'h00000001, 32'h000000FF}};
    vecs[2] = '{"sgn_zero", 1'b1, 32'h00000000, 128'h0};
    vecs[3] = '{"sgn_neg",  1'b1, 32'h8081FE02,
                {32'hFFFFFF80, 32'hFFFFFF81, 32'hFFFFFFFE, 32'h00000002}};
    vecs[4] = '{"uns_neg",  1'b0, 32'h8081FE02,
                {32'h00000080, 32'h00000081, 32'h000000FE, 32'h00000002}};
    vecs[5] = '{"uns_ones", 1'b0, 32'hFFFFFFFF, {4{32'h000000FF}}};

    bp_in[0] = 32'h80808080; bp_exp[0] = {4{32'h00000080}};
    bp_in[1] = 32'h81818181; bp_exp[1] = {4{32'h00000081}};
    bp_in[2] = 32'h82828282; bp_exp[2] = {4{32'h00000082}};

    rstnn                = 1'b0;
    u_if.inst_valid      = 1'b0;
    u_if.inst_num_row_m1 = '0;
    u_if.inst_num_col_m1 = '0;
    u_if.inst_is_signed  = 1'b0;
    u_if.elem_valid      = 1'b0;
    u_if.elem_row        = '0;
    u_if.tensor_ready    = 1'b0;

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rstnn = 1'b1;

    // Single-row instructions from the vector table.
    for (int i = 0; i < 6; i++) begin
      start_inst(4'd0, 2'd3, vecs[i].sgn);
      send_single(vecs[i].name, vecs[i].row, vecs[i].exp);
    end

    // Two-row signed load: first row not last, second row last, then done.
    start_inst(4'd1, 2'd3, 1'b1);
    u_if.tensor_ready = 1'b1;
    u_if.elem_valid   = 1'b1;
    u_if.elem_row     = vecs[0].row;
    @(negedge clk);
    check("two_r0_tvalid", u_if.tensor_valid, 1'b1);
    check("two_r0_row", u_if.tensor_row, vecs[0].exp);
    check("two_r0_last", u_if.tensor_last, 1'b0);
    @(negedge clk);
    u_if.elem_valid = 1'b0;
    check("two_r1_last", u_if.tensor_last, 1'b1);
    check("two_r1_row", u_if.tensor_row, vecs[0].exp);
    check("two_drain_elem_ready", u_if.elem_ready, 1'b0);
    check("two_no_early_done", u_if.done, 1'b0);
    @(negedge clk);
    check("two_done", u_if.done, 1'b1);
    @(negedge clk);
    check("two_done_pulse", u_if.done, 1'b0);

    // Backpressure: three rows offered with the consumer stalled.
    start_inst(4'd2, 2'd3, 1'b0);
    u_if.tensor_ready = 1'b0;
    u_if.elem_valid   = 1'b1;
    u_if.elem_row     = bp_in[0];
    check("bp_ready0", u_if.elem_ready, 1'b1);
    @(negedge clk);
    u_if.elem_row = bp_in[1];
    check("bp_tvalid", u_if.tensor_valid, 1'b1);
    check("bp_row0", u_if.tensor_row, bp_exp[0]);
    @(negedge clk);
    u_if.elem_row = bp_in[2];
    check("bp_full", u_if.elem_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_hold_row", u_if.tensor_row, bp_exp[0]);
      check("bp_hold_last", u_if.tensor_last, 1'b0);
      check("bp_hold_ready", u_if.elem_ready, 1'b0);
    end
    u_if.tensor_ready = 1'b1;
    got   = 0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (u_if.done) dones++;
      if (u_if.tensor_valid) begin
        if (got < 3) begin
          check("bp_drain_row", u_if.tensor_row, bp_exp[got]);
          check("bp_drain_last", u_if.tensor_last, (got == 2));
        end
        got++;
      end
      accept_pending = u_if.elem_valid & u_if.elem_ready;
      @(negedge clk);
      if (accept_pending) u_if.elem_valid = 1'b0;
    end
    check("bp_row_count", got, 3);
    check("bp_done_count", dones, 1);

    // Back-to-back instruction in the done cycle.
    start_inst(4'd0, 2'd3, 1'b1);
    send_single("b2b_a", vecs[3].row, vecs[3].exp);
    u_if.inst_valid      = 1'b1;
    u_if.inst_num_row_m1 = 4'd0;
    u_if.inst_is_signed  = 1'b0;
    @(negedge clk);
    u_if.inst_valid = 1'b0;
    check("b2b_accepted", u_if.inst_ready, 1'b0);
    send_single("b2b_b", vecs[4].row, vecs[4].exp);

    // Column count of two: upper columns masked only when the feature is built in.
    start_inst(4'd0, 2'd1, 1'b0);
`ifdef DCA_LSU_LOAD_COLMASK_EN
    mask_exp = {32'h0, 32'h0, 32'h00000033, 32'h00000044};
`else
    mask_exp = {32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};
`endif
    send_single("colmask", 32'h11223344, mask_exp);

    // Reset in RUN after one of four rows.
    start_inst(4'd3, 2'd3, 1'b1);
    u_if.tensor_ready = 1'b0;
    u_if.elem_valid   = 1'b1;
    u_if.elem_row     = vecs[0].row;
    @(negedge clk);
    u_if.elem_valid = 1'b0;
    check("rst_pre_tvalid", u_if.tensor_valid, 1'b1);
    #2;
    rstnn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_hold_done", u_if.done, 1'b0);
      check("rst_hold_tvalid", u_if.tensor_valid, 1'b0);
    end
    rstnn = 1'b1;
    @(negedge clk);
    check("rst_after_done", u_if.done, 1'b0);
    start_inst(4'd0, 2'd3, 1'b0);
    send_single("rst_clean", vecs[1].row, vecs[1].exp);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
